// File: rtl/fifo_pkg.sv
// Shared constants and types for the FIFO read-side drain engine
// (fifo_rd_stream and its 2-entry output buffer).
package fifo_pkg;

    localparam int READ_LATENCY_0    = 0;
    localparam int READ_LATENCY_1    = 1;
    localparam int BUF_DEPTH         = 2;
    localparam int OCC_WIDTH         = $clog2(BUF_DEPTH + 1);
    localparam int CNT_WIDTH_DEFAULT = 16;

    typedef enum logic [OCC_WIDTH-1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_e;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry output buffer: occupancy FSM, tail capture of returning FIFO data,
// head always in entry 0 with shift-on-dequeue.
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ret,
    input  logic [DATA_WIDTH-1:0] ret_data,
    input  logic                  ready,
    output logic                  valid,
    output logic                  deq,
    output logic [DATA_WIDTH-1:0] data,
    output logic [OCC_WIDTH-1:0]  occ
);

    occ_state_e            state;
    occ_state_e            state_next;
    logic [DATA_WIDTH-1:0] entry [BUF_DEPTH];
    logic                  wr_idx;

    assign valid = (state != OCC_EMPTY);
    assign deq   = valid & ready;
    assign data  = entry[0];
    assign occ   = state;

    // Tail slot as seen after this cycle's dequeue has shifted the buffer.
    assign wr_idx = (state == OCC_TWO) || ((state == OCC_ONE) && !deq);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= OCC_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: default assigned first so no path through the case leaves
    // state_next unassigned and infers a latch.
    always_comb begin
        state_next = state;
        case ({ret, deq})
            2'b10: begin
                case (state)
                    OCC_EMPTY: state_next = OCC_ONE;
                    OCC_ONE:   state_next = OCC_TWO;
                    default:   state_next = state;
                endcase
            end
            2'b01: begin
                case (state)
                    OCC_TWO: state_next = OCC_ONE;
                    OCC_ONE: state_next = OCC_EMPTY;
                    default: state_next = state;
                endcase
            end
            default: state_next = state;
        endcase
    end

    // NOTE: the data entries are reset because the head entry is the visible
    // o_m_data output, which must read zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entry[0] <= '0;
            entry[1] <= '0;
        end else begin
            if (deq && (state == OCC_TWO)) begin
                entry[0] <= entry[1];
            end
            if (ret) begin
                entry[wr_idx] <= ret_data;
            end
        end
    end

    // The credit rule upstream keeps a return from ever meeting a full buffer.
    no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(ret && !deq && (state == OCC_TWO)))
        else $error("fifo_skid_buf: return into full buffer");

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side drain engine: credit-based pops against the FIFO read port feeding a
// 2-entry buffer presented as a valid/ready stream. Optional pop counter: FIFO_RD_STREAM_CNT_EN.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = READ_LATENCY_1,
    parameter int CNT_WIDTH    = CNT_WIDTH_DEFAULT
) (
    input  logic                  i_clk_read,
    input  logic                  i_RST,
    output logic                  o_fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] i_fifo_rd_data,
    input  logic                  i_fifo_empty,
    output logic                  o_m_valid,
    output logic [DATA_WIDTH-1:0] o_m_data,
    input  logic                  i_m_ready
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  o_pop_count
`endif
);

    logic                 inflight;
    logic                 ret;
    logic                 deq;
    logic [OCC_WIDTH-1:0] occ;
    logic [OCC_WIDTH:0]   credit_used;

    // Slots committed after this cycle's dequeue; the ready->rd_en path is
    // combinational so a full buffer can still pop while it drains.
    assign credit_used  = {1'b0, occ} + (OCC_WIDTH+1)'(inflight) - (OCC_WIDTH+1)'(deq);
    assign o_fifo_rd_en = ~i_RST & ~i_fifo_empty & (credit_used < (OCC_WIDTH+1)'(BUF_DEPTH));

    generate
        if (READ_LATENCY == READ_LATENCY_0) begin : g_lat0
            assign inflight = 1'b0;
            assign ret      = o_fifo_rd_en;
        end else begin : g_lat1
            logic inflight_q;

            always_ff @(posedge i_clk_read or posedge i_RST) begin
                if (i_RST) begin
                    inflight_q <= 1'b0;
                end else begin
                    inflight_q <= o_fifo_rd_en;
                end
            end

            assign inflight = inflight_q;
            assign ret      = inflight_q;
        end
    endgenerate

    fifo_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk      (i_clk_read),
        .rst      (i_RST),
        .ret      (ret),
        .ret_data (i_fifo_rd_data),
        .ready    (i_m_ready),
        .valid    (o_m_valid),
        .deq      (deq),
        .data     (o_m_data),
        .occ      (occ)
    );

`ifdef FIFO_RD_STREAM_CNT_EN
    always_ff @(posedge i_clk_read or posedge i_RST) begin
        if (i_RST) begin
            o_pop_count <= '0;
        end else if (deq) begin
            o_pop_count <= o_pop_count + CNT_WIDTH'(1);
        end
    end
`endif

endmodule
